queue_serializer: RTL

Downstream stage of the byte queue in top. Pops one byte at a time from the queue head and shifts it out bit-serially, MSB first, with a valid strobe and frame-start marker. It mirrors the deserializer on the input side, closing the path deserializer -> queue -> serializer.

---
 rtl/queue_serializer_if.sv | 26 ++
 rtl/queue_serializer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/queue_serializer_if.sv
// Serializer-side bundle: queue head/occupancy in, pop strobe and serial frame out.
// Latency: n/a (signal bundle only). Backpressure: none; the serializer paces pops itself.
interface queue_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  enable_in;
    logic [LEN_WIDTH-1:0]  len_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  dequeue_out;
    logic                  serial_out;
    logic                  serial_valid;
    logic                  frame_start;
    logic                  busy;
    logic [7:0]            frames_out;

    modport master (
        input  enable_in, len_in, data_in,
        output dequeue_out, serial_out, serial_valid, frame_start, busy, frames_out
    );

    modport slave (
        output enable_in, len_in, data_in,
        input  dequeue_out, serial_out, serial_valid, frame_start, busy, frames_out
    );
endinterface

// File: rtl/queue_serializer.sv
// Pops the queue head and shifts it out MSB first; optional even-parity bit under QUEUE_SERIALIZER_PARITY_EN.
// Latency: first bit and pop strobe one cycle after the IDLE start decision; all outputs registered.
// Backpressure: none downstream; starts only with enable_in high and a non-empty queue, frames always complete.
module queue_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1,
    parameter int LEN_WIDTH  = 4
) (
    input  logic               clock,
    input  logic               reset,
    queue_serializer_if.master bus
);
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef QUEUE_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

    localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_t                state_q, state_n;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_n;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_n;
    logic                  deq_n, so_n, sv_n, fs_n, busy_n;
    logic [7:0]            frames_n;
`ifdef QUEUE_SERIALIZER_PARITY_EN
    logic                  par_q, par_n;
`endif

    always_comb begin
        state_n   = state_q;
        shreg_n   = shreg_q;
        bit_cnt_n = bit_cnt_q;
        gap_cnt_n = gap_cnt_q;
        frames_n  = bus.frames_out;
        deq_n     = 1'b0;
        so_n      = 1'b0;
        sv_n      = 1'b0;
        fs_n      = 1'b0;
`ifdef QUEUE_SERIALIZER_PARITY_EN
        par_n     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.enable_in && (bus.len_in != LEN_WIDTH'(0))) begin
                    // shreg holds the bits still to send, pre-shifted past the MSB sent now
                    shreg_n   = {bus.data_in[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_n = '0;
                    deq_n     = 1'b1;
                    fs_n      = 1'b1;
                    sv_n      = 1'b1;
                    so_n      = bus.data_in[DATA_WIDTH-1];
                    frames_n  = bus.frames_out + 8'd1;
                    state_n   = S_SHIFT;
`ifdef QUEUE_SERIALIZER_PARITY_EN
                    par_n     = ^bus.data_in;
`endif
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
`ifdef QUEUE_SERIALIZER_PARITY_EN
                    state_n = S_PARITY;
                    sv_n    = 1'b1;
                    so_n    = par_q;
`else
                    state_n   = AFTER_FRAME;
                    gap_cnt_n = '0;
`endif
                end else begin
                    sv_n      = 1'b1;
                    so_n      = shreg_q[DATA_WIDTH-1];
                    shreg_n   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_n = bit_cnt_q + 1'b1;
                end
            end
`ifdef QUEUE_SERIALIZER_PARITY_EN
            S_PARITY: begin
                state_n   = AFTER_FRAME;
                gap_cnt_n = '0;
            end
`endif
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt_q + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            shreg_q          <= '0;
            bit_cnt_q        <= '0;
            gap_cnt_q        <= '0;
            bus.dequeue_out  <= 1'b0;
            bus.serial_out   <= 1'b0;
            bus.serial_valid <= 1'b0;
            bus.frame_start  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.frames_out   <= 8'd0;
`ifdef QUEUE_SERIALIZER_PARITY_EN
            par_q            <= 1'b0;
`endif
        end else begin
            state_q          <= state_n;
            shreg_q          <= shreg_n;
            bit_cnt_q        <= bit_cnt_n;
            gap_cnt_q        <= gap_cnt_n;
            bus.dequeue_out  <= deq_n;
            bus.serial_out   <= so_n;
            bus.serial_valid <= sv_n;
            bus.frame_start  <= fs_n;
            bus.busy         <= busy_n;
            bus.frames_out   <= frames_n;
`ifdef QUEUE_SERIALIZER_PARITY_EN
            par_q            <= par_n;
`endif
        end
    end
endmodule
